mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundled request/grant, read-return and RAM-drive signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface mem_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic              stall;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [DATA_W-1:0] if_rdata;
   logic              if_rvalid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rvalid;
   logic              addr_err;
   logic [ADDR_W-1:0] ram_add;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_r_w;
   logic              ram_enable;
   logic              ram_ce;
   logic [DATA_W-1:0] ram_data_out;

   modport slave (
      input  stall, if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
      output if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid, addr_err,
      output ram_add, ram_data_in, ram_r_w, ram_enable, ram_ce
   );

   modport master (
      output stall, if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
      input  if_gnt, if_rdata, if_rvalid, d_gnt, d_rdata, d_rvalid, addr_err,
      input  ram_add, ram_data_in, ram_r_w, ram_enable, ram_ce
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-RAM arbiter between an instruction-fetch read port and a data read/write port.
// Data has priority, but fetch is forced through after two consecutive data wins.
//
// read tag  | meaning
// TAG_NONE  | no read return pending this cycle
// TAG_FETCH | fetch read granted last cycle, return on if_* this cycle
// TAG_DATA  | data read granted last cycle, return on d_* this cycle
module mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_DATA} tag_e;

   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   tag_e              tag_q, tag_d;
   logic              oor_q, oor_d;
   logic              err_q, err_d;
   logic [1:0]        streak_q, streak_d;
   logic              open_c;
   logic              d_gnt_c, if_gnt_c, any_gnt_c, in_range_c;
   logic [ADDR_W-1:0] gnt_addr_c;
   logic              if_rvalid_c, d_rvalid_c;

   always_comb begin
      open_c     = rst_n && !bus.stall;
      d_gnt_c    = open_c && bus.d_req && !(streak_q == 2'd2 && bus.if_req);
      if_gnt_c   = open_c && bus.if_req && !d_gnt_c;
      any_gnt_c  = d_gnt_c || if_gnt_c;
      gnt_addr_c = d_gnt_c ? bus.d_addr : bus.if_addr;
      in_range_c = {1'b0, gnt_addr_c} < DEPTH_L;

      streak_d = streak_q;
      if (!bus.stall) begin
         if (!bus.if_req || if_gnt_c)
            streak_d = 2'd0;
         else if (d_gnt_c && streak_q != 2'd2)
            streak_d = streak_q + 2'd1;
      end

      tag_d = TAG_NONE;
      if (d_gnt_c && !bus.d_we)
         tag_d = TAG_DATA;
      else if (if_gnt_c)
         tag_d = TAG_FETCH;
      oor_d = any_gnt_c && !in_range_c;
      err_d = oor_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q    <= TAG_NONE;
         oor_q    <= 1'b0;
         err_q    <= 1'b0;
         streak_q <= 2'd0;
      end else begin
         tag_q    <= tag_d;
         oor_q    <= oor_d;
         err_q    <= err_d;
         streak_q <= streak_d;
      end
   end

   // Returns are gated by rst_n so a read granted just before reset never completes.
   assign if_rvalid_c = rst_n && (tag_q == TAG_FETCH);
   assign d_rvalid_c  = rst_n && (tag_q == TAG_DATA);

   assign bus.if_gnt      = if_gnt_c;
   assign bus.d_gnt       = d_gnt_c;
   assign bus.if_rvalid   = if_rvalid_c;
   assign bus.d_rvalid    = d_rvalid_c;
   assign bus.if_rdata    = (if_rvalid_c && !oor_q) ? bus.ram_data_out : '0;
   assign bus.d_rdata     = (d_rvalid_c && !oor_q) ? bus.ram_data_out : '0;
   assign bus.addr_err    = rst_n && err_q;
   assign bus.ram_add     = gnt_addr_c;
   assign bus.ram_data_in = bus.d_wdata;
   assign bus.ram_r_w     = d_gnt_c && bus.d_we;
   assign bus.ram_enable  = any_gnt_c && in_range_c;
   assign bus.ram_ce      = open_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural registered-read RAM.
module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if #(.ADDR_W(6), .DATA_W(16)) bus ();

   mem_arbiter #(.ADDR_W(6), .DATA_W(16), .DEPTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [64];
   always @(posedge clk) begin
      if (bus.ram_enable) begin
         if (bus.ram_r_w) mem[bus.ram_add] <= bus.ram_data_in;
         else             bus.ram_data_out <= mem[bus.ram_add];
      end
   end

   task automatic drive(input logic st, input logic ir, input logic [5:0] ia,
                        input logic dr, input logic we, input logic [5:0] da,
                        input logic [15:0] wd);
      bus.stall   = st;
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = we;
      bus.d_addr  = da;
      bus.d_wdata = wd;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 6'd4, 16'h0);
      next_cycle();
      next_cycle();
      checks++;
      if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b required 0 0", bus.if_gnt, bus.d_gnt);
      end
      checks++;
      if (bus.ram_enable !== 1'b0 || bus.ram_ce !== 1'b0 || bus.ram_r_w !== 1'b0) begin
         errors++;
         $display("FAIL reset_ram: en=%b ce=%b rw=%b required 0 0 0", bus.ram_enable, bus.ram_ce, bus.ram_r_w);
      end
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.addr_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: if_rv=%b d_rv=%b err=%b required 0 0 0", bus.if_rvalid, bus.d_rvalid, bus.addr_err);
      end
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'h0);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_write_read();
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd7, 16'h1234);
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd5, 16'hBEEF);
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.ram_enable !== 1'b1 || bus.ram_r_w !== 1'b1 ||
          bus.ram_add !== 6'd5 || bus.ram_data_in !== 16'hBEEF) begin
         errors++;
         $display("FAIL wr_grant: gnt=%b en=%b rw=%b add=%0d din=%h required 1 1 1 5 beef",
                  bus.d_gnt, bus.ram_enable, bus.ram_r_w, bus.ram_add, bus.ram_data_in);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd5, 16'h0);
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.ram_r_w !== 1'b0 || bus.ram_enable !== 1'b1 || bus.d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_grant: gnt=%b rw=%b en=%b d_rvalid=%b required 1 0 1 0",
                  bus.d_gnt, bus.ram_r_w, bus.ram_enable, bus.d_rvalid);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'h0);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 16'hBEEF || bus.if_rvalid !== 1'b0 || bus.if_rdata !== 16'h0) begin
         errors++;
         $display("FAIL rd_return: d_rv=%b d_rdata=%h if_rv=%b if_rdata=%h required 1 beef 0 0",
                  bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata);
      end
      checks++;
      if (bus.ram_enable !== 1'b0 || bus.ram_r_w !== 1'b0 || bus.ram_ce !== 1'b1) begin
         errors++;
         $display("FAIL idle_ram: en=%b rw=%b ce=%b required 0 0 1", bus.ram_enable, bus.ram_r_w, bus.ram_ce);
      end
      next_cycle();
   endtask

   task automatic test_fairness();
      logic exp_d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic prev_d;
      prev_d = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         if (k < 6) drive(1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 6'd5, 16'h0);
         else       drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'h0);
         if (k < 6) begin
            checks++;
            if (bus.d_gnt !== exp_d[k] || bus.if_gnt !== !exp_d[k]) begin
               errors++;
               $display("FAIL fair_gnt[%0d]: d_gnt=%b if_gnt=%b required %b %b",
                        k, bus.d_gnt, bus.if_gnt, exp_d[k], !exp_d[k]);
            end
         end
         if (k > 0) begin
            checks++;
            if (bus.d_rvalid !== prev_d || bus.if_rvalid !== !prev_d ||
                bus.d_rdata !== (prev_d ? 16'hBEEF : 16'h0) ||
                bus.if_rdata !== (prev_d ? 16'h0 : 16'h1234)) begin
               errors++;
               $display("FAIL fair_ret[%0d]: d_rv=%b d_rdata=%h if_rv=%b if_rdata=%h required %b %h %b %h",
                        k, bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata, prev_d,
                        prev_d ? 16'hBEEF : 16'h0, !prev_d, prev_d ? 16'h0 : 16'h1234);
            end
         end
         if (k < 6) prev_d = exp_d[k];
         next_cycle();
      end
   endtask

   task automatic test_out_of_range();
      drive(1'b0, 1'b1, 6'd40, 1'b0, 1'b0, 6'd0, 16'h0);
      checks++;
      if (bus.if_gnt !== 1'b1 || bus.ram_enable !== 1'b0) begin
         errors++;
         $display("FAIL oor_if_gnt: if_gnt=%b en=%b required 1 0", bus.if_gnt, bus.ram_enable);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd50, 16'hDEAD);
      checks++;
      if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 16'h0 || bus.addr_err !== 1'b1) begin
         errors++;
         $display("FAIL oor_if_ret: if_rv=%b if_rdata=%h err=%b required 1 0 1", bus.if_rvalid, bus.if_rdata, bus.addr_err);
      end
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.ram_enable !== 1'b0) begin
         errors++;
         $display("FAIL oor_d_gnt: d_gnt=%b en=%b required 1 0", bus.d_gnt, bus.ram_enable);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd31, 1'b0, 1'b0, 6'd0, 16'h0);
      checks++;
      if (bus.addr_err !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL oor_d_ret: err=%b d_rv=%b if_rv=%b required 1 0 0", bus.addr_err, bus.d_rvalid, bus.if_rvalid);
      end
      next_cycle();
      checks++;
      if (bus.addr_err !== 1'b0) begin
         errors++;
         $display("FAIL oor_pulse: err=%b required 0", bus.addr_err);
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd7, 16'h0);
      next_cycle();
      drive(1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 6'd5, 16'h0);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
         errors++;
         $display("FAIL stall_ret: d_rv=%b d_rdata=%h required 1 1234", bus.d_rvalid, bus.d_rdata);
      end
      checks++;
      if (bus.d_gnt !== 1'b0 || bus.if_gnt !== 1'b0 || bus.ram_ce !== 1'b0 || bus.ram_enable !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: d_gnt=%b if_gnt=%b ce=%b en=%b required 0 0 0 0",
                  bus.d_gnt, bus.if_gnt, bus.ram_ce, bus.ram_enable);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'h0);
      checks++;
      if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 16'h0) begin
         errors++;
         $display("FAIL stall_once: d_rv=%b d_rdata=%h required 0 0", bus.d_rvalid, bus.d_rdata);
      end
      next_cycle();
   endtask

   task automatic test_reset_kill();
      drive(1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 16'h0);
      next_cycle();
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 6'd7, 1'b1, 1'b0, 6'd7, 16'h0);
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 16'h0 || bus.d_rvalid !== 1'b0 ||
          bus.d_rdata !== 16'h0 || bus.addr_err !== 1'b0) begin
         errors++;
         $display("FAIL rstkill_ret: if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h err=%b required 0 0 0 0 0",
                  bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata, bus.addr_err);
      end
      checks++;
      if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.ram_enable !== 1'b0 ||
          bus.ram_ce !== 1'b0 || bus.ram_r_w !== 1'b0) begin
         errors++;
         $display("FAIL rstkill_out: if_gnt=%b d_gnt=%b en=%b ce=%b rw=%b required 0 0 0 0 0",
                  bus.if_gnt, bus.d_gnt, bus.ram_enable, bus.ram_ce, bus.ram_r_w);
      end
      next_cycle();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd7, 16'h0);
      checks++;
      if (bus.d_gnt !== 1'b1 || bus.if_rvalid !== 1'b0 || bus.ram_enable !== 1'b1) begin
         errors++;
         $display("FAIL rstkill_regnt: d_gnt=%b if_rv=%b en=%b required 1 0 1", bus.d_gnt, bus.if_rvalid, bus.ram_enable);
      end
      next_cycle();
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 16'h0);
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 16'h1234) begin
         errors++;
         $display("FAIL rstkill_after: d_rv=%b d_rdata=%h required 1 1234", bus.d_rvalid, bus.d_rdata);
      end
      next_cycle();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0;
      bus.ram_data_out = 16'h0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_fairness();
      test_out_of_range();
      test_stall();
      test_reset_kill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
